fp_exception_stage: RTL and testbench

Parametrised, pipelined exception/special-case stage for the floating-point multiplier datapath, located after the normalise/round stage. Each accepted result is classified by operand class, rounding mode and overflow/underflow/inexact status. The stage substitutes the IEEE-754 special value where one applies, registers the result behind a valid/ready handshake, and accumulates sticky exception flags and a saturating exception counter for the status CSR.

---
 rtl/rounding_pkg.sv | 44 ++++
 rtl/fp_exception_stage_if.sv | 38 +++
 rtl/fp_classify.sv | 26 ++
 rtl/fp_exception_stage.sv | 144 ++++++++++++++
 tb/tb_fp_exception_stage.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/rounding_pkg.sv
// Shared types for the FP multiplier back end: rounding modes, operand
// classes, per-result flag bit positions and a rounding-direction helper.
package rounding_pkg;

    typedef enum logic [2:0] {
        IEEE_near = 3'b000,
        IEEE_zero = 3'b001,
        IEEE_pinf = 3'b010,
        IEEE_ninf = 3'b011,
        near_up   = 3'b100,
        away_zero = 3'b101
    } round_mode_t;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        INF  = 2'd1,
        NAN  = 2'd2,
        NORM = 2'd3
    } fp_class_t;

    // Bit positions in the flag vector {inexact,huge,tiny,nan,inf,zero}
    localparam int FLAG_ZERO    = 0;
    localparam int FLAG_INF     = 1;
    localparam int FLAG_NAN     = 2;
    localparam int FLAG_TINY    = 3;
    localparam int FLAG_HUGE    = 4;
    localparam int FLAG_INEXACT = 5;
    localparam int NUM_FLAGS    = 6;

    // True when an out-of-range result should move away from zero:
    // overflow then gives INF (else MAX_NORM), underflow gives MIN_NORM
    // (else zero). Reserved codes fall through to round-to-nearest.
    function automatic logic rounds_away(input logic [2:0] mode, input logic sign);
        logic away;
        case (round_mode_t'(mode))
            IEEE_zero:          away = 1'b0;
            IEEE_pinf, near_up: away = ~sign;
            IEEE_ninf:          away = sign;
            default:            away = 1'b1;
        endcase
        return away;
    endfunction

endpackage

// File: rtl/fp_exception_stage_if.sv
// Beat interface of the exception stage: operands, datapath result and
// status in, final result and per-result flags out, valid/ready both ways.
interface fp_exception_stage_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] z_calc;
    logic         overflow;
    logic         underflow;
    logic         inexact;
    logic [2:0]   round_mode;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z;
    logic         zero_f;
    logic         inf_f;
    logic         nan_f;
    logic         tiny_f;
    logic         huge_f;
    logic         inexact_f;

    modport master (
        output in_valid, a, b, z_calc, overflow, underflow, inexact, round_mode, out_ready,
        input  in_ready, out_valid, z, zero_f, inf_f, nan_f, tiny_f, huge_f, inexact_f
    );

    modport slave (
        input  in_valid, a, b, z_calc, overflow, underflow, inexact, round_mode, out_ready,
        output in_ready, out_valid, z, zero_f, inf_f, nan_f, tiny_f, huge_f, inexact_f
    );
endinterface

// File: rtl/fp_classify.sv
// Combinational operand classifier; denormals are treated as zero.
module fp_classify
    import rounding_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] op,
    output fp_class_t            cls
);
    logic [EXP_W-1:0] exp_field;
    logic [MAN_W-1:0] frac_field;

    assign exp_field  = op[EXP_W+MAN_W-1:MAN_W];
    assign frac_field = op[MAN_W-1:0];

    // Decode exponent/fraction into the operand class
    always_comb begin
        cls = NORM;
        if (&exp_field) begin
            cls = (|frac_field) ? NAN : INF;
        end else if (exp_field == '0) begin
            cls = ZERO;
        end
    end
endmodule

// File: rtl/fp_exception_stage.sv
// Exception/special-case stage after normalise/round: substitutes IEEE
// special values, registers the result behind valid/ready and keeps
// sticky flags plus a saturating exception counter for the status CSR.
module fp_exception_stage
    import rounding_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fp_exception_stage_if.slave     bus,
    input  logic                    flag_clr,
    output logic [NUM_FLAGS-1:0]    sticky_flags,
    output logic [CNT_W-1:0]        exc_cnt
);
    localparam int W = 1 + EXP_W + MAN_W;

    // Unsigned magnitudes of the substituted values; the sign is ORed in later
    localparam logic [W-1:0] INF_MAG  = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [W-1:0] MAX_MAG  = {1'b0, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    localparam logic [W-1:0] MIN_MAG  = {1'b0, {(EXP_W-1){1'b0}}, 1'b1, {MAN_W{1'b0}}};
    localparam logic [W-1:0] QNAN_VAL = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    fp_class_t cls_a;
    fp_class_t cls_b;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_a (.op(bus.a), .cls(cls_a));
    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_b (.op(bus.b), .cls(cls_b));

    logic                 out_valid_q, out_valid_d;
    logic [W-1:0]         z_q, z_d;
    logic [NUM_FLAGS-1:0] flags_q, flags_d;
    logic [NUM_FLAGS-1:0] sticky_q, sticky_d;
    logic [CNT_W-1:0]     exc_cnt_q, exc_cnt_d;

    logic                 accept;
    logic [W-1:0]         sign_bit;
    logic                 away;
    logic [W-1:0]         z_new;
    logic [NUM_FLAGS-1:0] flags_new;
    logic                 exc_hit;
    logic [CNT_W-1:0]     cnt_base;

    assign bus.in_ready = ~out_valid_q | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;
    assign sign_bit     = {bus.z_calc[W-1], {(W-1){1'b0}}};
    assign away         = rounds_away(bus.round_mode, bus.z_calc[W-1]);

    // Priority selection of the final value and its per-result flags
    always_comb begin
        z_new     = bus.z_calc;
        flags_new = '0;
        if (cls_a == NAN || cls_b == NAN ||
            (cls_a == ZERO && cls_b == INF) || (cls_a == INF && cls_b == ZERO)) begin
            z_new               = QNAN_VAL;
            flags_new[FLAG_NAN] = 1'b1;
        end else if (cls_a == INF || cls_b == INF) begin
            z_new               = sign_bit | INF_MAG;
            flags_new[FLAG_INF] = 1'b1;
        end else if (cls_a == ZERO || cls_b == ZERO) begin
            z_new                = sign_bit;
            flags_new[FLAG_ZERO] = 1'b1;
        end else if (bus.overflow) begin
            flags_new[FLAG_HUGE]    = 1'b1;
            flags_new[FLAG_INEXACT] = 1'b1;
            if (away) begin
                z_new               = sign_bit | INF_MAG;
                flags_new[FLAG_INF] = 1'b1;
            end else begin
                z_new = sign_bit | MAX_MAG;
            end
        end else if (bus.underflow) begin
            flags_new[FLAG_TINY]    = 1'b1;
            flags_new[FLAG_INEXACT] = 1'b1;
            if (away) begin
                z_new = sign_bit | MIN_MAG;
            end else begin
                z_new                = sign_bit;
                flags_new[FLAG_ZERO] = 1'b1;
            end
        end else begin
            flags_new[FLAG_INEXACT] = bus.inexact;
        end
    end

    assign exc_hit = flags_new[FLAG_NAN] | flags_new[FLAG_INF] |
                     flags_new[FLAG_TINY] | flags_new[FLAG_HUGE];

    // Next-state for output register, sticky flags and counter; a clear
    // applies first so a same-cycle accepted beat still contributes
    always_comb begin
        out_valid_d = out_valid_q;
        z_d         = z_q;
        flags_d     = flags_q;
        if (accept) begin
            out_valid_d = 1'b1;
            z_d         = z_new;
            flags_d     = flags_new;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        sticky_d = flag_clr ? '0 : sticky_q;
        if (accept) begin
            sticky_d = sticky_d | flags_new;
        end

        cnt_base  = flag_clr ? '0 : exc_cnt_q;
        exc_cnt_d = cnt_base;
        if (accept && exc_hit && (cnt_base != '1)) begin
            exc_cnt_d = cnt_base + CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            z_q         <= '0;
            flags_q     <= '0;
            sticky_q    <= '0;
            exc_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            flags_q     <= flags_d;
            sticky_q    <= sticky_d;
            exc_cnt_q   <= exc_cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.z         = z_q;
    assign bus.zero_f    = flags_q[FLAG_ZERO];
    assign bus.inf_f     = flags_q[FLAG_INF];
    assign bus.nan_f     = flags_q[FLAG_NAN];
    assign bus.tiny_f    = flags_q[FLAG_TINY];
    assign bus.huge_f    = flags_q[FLAG_HUGE];
    assign bus.inexact_f = flags_q[FLAG_INEXACT];
    assign sticky_flags  = sticky_q;
    assign exc_cnt       = exc_cnt_q;
endmodule

// File: tb/tb_fp_exception_stage.sv
// Scoreboard bench for fp_exception_stage: directed beats push expected
// results into a queue, a monitor pops and compares on each output transfer.
module tb_fp_exception_stage;
    localparam int CNT_W = 8;

    typedef struct {
        logic [31:0] z;
        logic [5:0]  f;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flag_clr = 1'b0;
    logic [5:0] sticky_flags;
    logic [CNT_W-1:0] exc_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;
    int txn_cnt = 0;
    exp_t exp_q[$];

    fp_exception_stage_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_exception_stage #(.EXP_W(8), .MAN_W(23), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .flag_clr     (flag_clr),
        .sticky_flags (sticky_flags),
        .exc_cnt      (exc_cnt)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endfunction

    // Monitor: compare every output transfer against the queue head
    always @(negedge clk) begin
        #1;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_output: got z=%h with empty scoreboard", bus.z);
            end else begin
                exp_t e;
                logic [5:0] f;
                e = exp_q.pop_front();
                f = {bus.inexact_f, bus.huge_f, bus.tiny_f, bus.nan_f, bus.inf_f, bus.zero_f};
                txn_cnt++;
                $display("txn %0d: z=%h flags=%b (expected z=%h flags=%b)", txn_cnt, bus.z, f, e.z, e.f);
                check("txn_z", 64'(bus.z), 64'(e.z));
                check("txn_flags", 64'(f), 64'(e.f));
            end
        end
    end

    // Drive one beat from the negedge phase; returns at the negedge after acceptance
    task automatic send(input logic [31:0] ta, input logic [31:0] tb_op, input logic [31:0] tzc,
                        input logic tov, input logic tun, input logic tix, input logic [2:0] tm,
                        input logic [31:0] ez, input logic [5:0] ef);
        int n;
        exp_t e;
        bus.in_valid   = 1'b1;
        bus.a          = ta;
        bus.b          = tb_op;
        bus.z_calc     = tzc;
        bus.overflow   = tov;
        bus.underflow  = tun;
        bus.inexact    = tix;
        bus.round_mode = tm;
        n = 0;
        #1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            total_cnt++;
            $display("FAIL send_timeout: in_ready stayed 0 after %0d cycles, required 1", n);
            bus.in_valid = 1'b0;
            return;
        end
        e.z = ez;
        e.f = ef;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] z_hold;
        int prev_txn;
        int n;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus.a          = '0;
        bus.b          = '0;
        bus.z_calc     = '0;
        bus.overflow   = 1'b0;
        bus.underflow  = 1'b0;
        bus.inexact    = 1'b0;
        bus.round_mode = 3'b000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_z", 64'(bus.z), 64'd0);
        check("reset_sticky", 64'(sticky_flags), 64'd0);
        check("reset_cnt", 64'(exc_cnt), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);

        // INF x ZERO -> qNaN
        send(32'h7F800000, 32'h00000000, 32'h12345678, 0, 0, 0, 3'b001, 32'h7FC00000, 6'b000100);
        check("cnt_after_nan", 64'(exc_cnt), 64'd1);
        // NaN operand, ZERO x -INF (reversed order)
        send(32'h3F800000, 32'h7FA00000, 32'h3F800000, 0, 0, 1, 3'b000, 32'h7FC00000, 6'b000100);
        send(32'h00000000, 32'hFF800000, 32'h80000000, 0, 0, 0, 3'b000, 32'h7FC00000, 6'b000100);
        // INF with negative product
        send(32'hBF800000, 32'h7F800000, 32'h80000000, 0, 0, 0, 3'b000, 32'hFF800000, 6'b000010);
        // ZERO operand (signed), denormal flushed to zero
        send(32'h00000000, 32'hBF800000, 32'h80000000, 0, 0, 0, 3'b000, 32'h80000000, 6'b000001);
        send(32'h00000001, 32'h40000000, 32'h00000005, 0, 0, 1, 3'b000, 32'h00000000, 6'b000001);
        // Overflow, negative product
        send(32'h40000000, 32'hC0000000, 32'hC1000000, 1, 0, 1, 3'b001, 32'hFF7FFFFF, 6'b110000);
        send(32'h40000000, 32'hC0000000, 32'hC1000000, 1, 0, 1, 3'b011, 32'hFF800000, 6'b110010);
        send(32'h40000000, 32'hC0000000, 32'hC1000000, 1, 0, 1, 3'b000, 32'hFF800000, 6'b110010);
        send(32'h40000000, 32'hC0000000, 32'hC1000000, 1, 0, 1, 3'b010, 32'hFF7FFFFF, 6'b110000);
        send(32'h40000000, 32'hC0000000, 32'hC1000000, 1, 1, 1, 3'b001, 32'hFF7FFFFF, 6'b110000);
        // Underflow
        send(32'h20000000, 32'h20000000, 32'h00000001, 0, 1, 1, 3'b010, 32'h00800000, 6'b101000);
        send(32'h20000000, 32'h20000000, 32'h00000001, 0, 1, 1, 3'b011, 32'h00000000, 6'b101001);
        send(32'h20000000, 32'h20000000, 32'h00000001, 0, 1, 1, 3'b111, 32'h00800000, 6'b101000);
        send(32'h20000000, 32'hA0000000, 32'h80000001, 0, 1, 1, 3'b100, 32'h80000000, 6'b101001);
        // Pass-through
        send(32'h3FC00000, 32'h40000000, 32'h40490FDB, 0, 0, 1, 3'b000, 32'h40490FDB, 6'b100000);
        send(32'h3FC00000, 32'h40000000, 32'h40400000, 0, 0, 0, 3'b101, 32'h40400000, 6'b000000);

        // Back-pressure: first beat lands, then a 3-cycle stall
        prev_txn = txn_cnt + exp_q.size();
        send(32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 0, 0, 3'b000, 32'h3F800000, 6'b000000);
        bus.out_ready = 1'b0;
        z_hold = 32'h3F800000;
        fork
            begin
                send(32'h40000000, 32'h3F800000, 32'h40000000, 0, 0, 1, 3'b000, 32'h40000000, 6'b100000);
                send(32'h40400000, 32'h3F800000, 32'h40400000, 0, 0, 0, 3'b000, 32'h40400000, 6'b000000);
                send(32'h40800000, 32'h3F800000, 32'h40800000, 0, 0, 0, 3'b000, 32'h40800000, 6'b000000);
            end
            begin
                repeat (3) begin
                    #1;
                    check("stall_in_ready", 64'(bus.in_ready), 64'd0);
                    check("stall_out_valid", 64'(bus.out_valid), 64'd1);
                    check("stall_z_stable", 64'(bus.z), 64'(z_hold));
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
            end
        join
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #2;
        check("stream_transfers", 64'(txn_cnt - prev_txn), 64'd4);

        // Reset while a beat is stalled at the output
        send(32'h7F800000, 32'h3F800000, 32'h00000000, 0, 0, 0, 3'b000, 32'h7F800000, 6'b000010);
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_z", 64'(bus.z), 64'd0);
        check("midrst_sticky", 64'(sticky_flags), 64'd0);
        check("midrst_cnt", 64'(exc_cnt), 64'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);

        // Sticky accumulation and clear coincident with a huge beat
        send(32'h20000000, 32'h20000000, 32'h00000001, 0, 1, 1, 3'b000, 32'h00800000, 6'b101000);
        check("sticky_tiny", 64'(sticky_flags), 64'b101000);
        send(32'h3FC00000, 32'h40000000, 32'h40490FDB, 0, 0, 1, 3'b000, 32'h40490FDB, 6'b100000);
        check("sticky_inexact", 64'(sticky_flags), 64'b101000);
        check("cnt_before_clr", 64'(exc_cnt), 64'd1);
        flag_clr = 1'b1;
        send(32'h40000000, 32'h40000000, 32'h41000000, 1, 0, 1, 3'b001, 32'h7F7FFFFF, 6'b110000);
        flag_clr = 1'b0;
        check("sticky_clr_huge", 64'(sticky_flags), 64'b110000);
        check("cnt_clr_huge", 64'(exc_cnt), 64'd1);
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        check("sticky_clr_only", 64'(sticky_flags), 64'd0);
        check("cnt_clr_only", 64'(exc_cnt), 64'd0);

        // Saturation of the exception counter
        for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
            send(32'h7FC00000, 32'h3F800000, 32'h00000000, 0, 0, 0, 3'b000, 32'h7FC00000, 6'b000100);
        end
        check("cnt_full", 64'(exc_cnt), 64'((1 << CNT_W) - 1));
        send(32'h7FC00000, 32'h3F800000, 32'h00000000, 0, 0, 0, 3'b000, 32'h7FC00000, 6'b000100);
        check("cnt_saturated", 64'(exc_cnt), 64'((1 << CNT_W) - 1));

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #2;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
